// File: rtl/csr_pkg.sv
// Shared constants, FSM state type and bus type for the CSR encoder slice.
// Optional RP padding in FINISH is enabled by defining CSR_ENC_RP_PAD_EN.
package csr_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SLOTS    = 16;
  localparam int unsigned MAX_COLS = 16;

  typedef enum logic [1:0] {IDLE, LOAD, FINISH, DONE} csr_enc_state_t;

  // Slot 0 sits in the most significant word of the packed bus.
  typedef logic [0:SLOTS-1][DATA_W-1:0] csr_bus_t;

  function automatic logic [DATA_W-1:0] pack_idx(input logic [3:0] idx);
    return {{(DATA_W-4){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/csr_slot_writer.sv
// One SLOTS-entry register array with indexed write, bulk clear and
// tail padding (every slot at or above pad_from_i takes pad_val_i).
module csr_slot_writer
  import csr_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [3:0]        idx_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pad_en_i,
  input  logic [4:0]        pad_from_i,
  input  logic [DATA_W-1:0] pad_val_i,
  output csr_bus_t          bus_o
);

  csr_bus_t slots_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slots_q <= '0;
    end else if (clr_i) begin
      slots_q <= '0;
    end else begin
      for (int unsigned k = 0; k < SLOTS; k++) begin
        if (we_i && idx_i == 4'(k)) begin
          slots_q[k] <= data_i;
        end else if (pad_en_i && 5'(k) >= pad_from_i) begin
          slots_q[k] <= pad_val_i;
        end
      end
    end
  end

  assign bus_o = slots_q;

endmodule

// File: rtl/csr_encoder.sv
// Dense row-major stream to CSR (NV/CI/RP) encoder feeding the CSR multiplier.
// Define CSR_ENC_RP_PAD_EN to fill RP slots past the last row with nnz in FINISH.
module csr_encoder
  import csr_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [3:0]              rows_i,
  input  logic [4:0]              cols_i,
  input  logic                    elem_valid_i,
  input  logic [DATA_W-1:0]       elem_i,
  output logic                    elem_ready_o,
  output logic [SLOTS*DATA_W-1:0] NV_o,
  output logic [SLOTS*DATA_W-1:0] CI_o,
  output logic [SLOTS*DATA_W-1:0] RP_o,
  output logic [3:0]              rows_o,
  output logic [4:0]              nnz_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ovf_o
);

  localparam logic [4:0] SLOTS_N    = 5'(SLOTS);
  localparam logic [4:0] MAX_COLS_N = 5'(MAX_COLS);

  csr_enc_state_t state_q, state_d;

  logic [3:0] rows_q;
  logic [4:0] cols_q;
  logic [3:0] r_q;
  logic [4:0] c_q;
  logic [4:0] nnz_q;
  logic       ovf_q;

  logic       start_acc, dims_bad, accept, last_col, last_elem;
  logic       nz, store, drop, pad_en;
  logic [4:0] nnz_inc;

  csr_bus_t nv_bus, ci_bus, rp_bus;

  assign start_acc = start_i && (state_q == IDLE || state_q == DONE);
  assign dims_bad  = (rows_i == '0) || (cols_i == '0) || (cols_i > MAX_COLS_N);
  assign accept    = elem_valid_i && (state_q == LOAD);
  assign last_col  = (c_q == cols_q - 5'd1);
  assign last_elem = last_col && (r_q == rows_q - 4'd1);
  assign nz        = (elem_i != '0);
  assign store     = accept && nz && (nnz_q < SLOTS_N);
  assign drop      = accept && nz && (nnz_q == SLOTS_N);
  assign nnz_inc   = store ? nnz_q + 5'd1 : nnz_q;

`ifdef CSR_ENC_RP_PAD_EN
  assign pad_en = (state_q == FINISH);
`else
  assign pad_en = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_i) state_d = dims_bad ? FINISH : LOAD;
      LOAD:       if (accept && last_elem) state_d = FINISH;
      FINISH:     state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      nnz_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        rows_q <= rows_i;
        cols_q <= cols_i;
        r_q    <= '0;
        c_q    <= '0;
        nnz_q  <= '0;
        ovf_q  <= 1'b0;
      end else if (accept) begin
        nnz_q <= nnz_inc;
        if (drop) ovf_q <= 1'b1;
        if (last_col) begin
          c_q <= '0;
          r_q <= r_q + 4'd1;
        end else begin
          c_q <= c_q + 5'd1;
        end
      end
    end
  end

  csr_slot_writer u_nv (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (start_acc),
    .we_i       (store),
    .idx_i      (nnz_q[3:0]),
    .data_i     (elem_i),
    .pad_en_i   (1'b0),
    .pad_from_i ('0),
    .pad_val_i  ('0),
    .bus_o      (nv_bus)
  );

  csr_slot_writer u_ci (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (start_acc),
    .we_i       (store),
    .idx_i      (nnz_q[3:0]),
    .data_i     (pack_idx(c_q[3:0])),
    .pad_en_i   (1'b0),
    .pad_from_i ('0),
    .pad_val_i  ('0),
    .bus_o      (ci_bus)
  );

  // RP[r+1] takes the count including the element that closes row r.
  csr_slot_writer u_rp (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (start_acc),
    .we_i       (accept && last_col),
    .idx_i      (r_q + 4'd1),
    .data_i     ({{(DATA_W-5){1'b0}}, nnz_inc}),
    .pad_en_i   (pad_en),
    .pad_from_i ({1'b0, rows_q} + 5'd1),
    .pad_val_i  ({{(DATA_W-5){1'b0}}, nnz_q}),
    .bus_o      (rp_bus)
  );

  assign NV_o         = nv_bus;
  assign CI_o         = ci_bus;
  assign RP_o         = rp_bus;
  assign rows_o       = rows_q;
  assign nnz_o        = nnz_q;
  assign ovf_o        = ovf_q;
  assign elem_ready_o = (state_q == LOAD);
  assign busy_o       = (state_q == LOAD) || (state_q == FINISH);
  assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_csr_encoder.sv
// Self-checking bench for csr_encoder: directed scenarios plus randomized matrices
// checked against a prefix-count CSR model (honours CSR_ENC_RP_PAD_EN).
module tb_csr_encoder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [3:0]   rows_i;
  logic [4:0]   cols_i;
  logic         elem_valid_i;
  logic [31:0]  elem_i;
  logic         elem_ready_o;
  logic [511:0] NV_o, CI_o, RP_o;
  logic [3:0]   rows_o;
  logic [4:0]   nnz_o;
  logic         busy_o, done_o, ovf_o;

  int tests = 0;
  int fails = 0;

  logic [31:0]  mat [0:255];
  logic [511:0] exp_nv, exp_ci, exp_rp;
  int           exp_nnz;
  bit           exp_ovf;

  csr_encoder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .rows_i       (rows_i),
    .cols_i       (cols_i),
    .elem_valid_i (elem_valid_i),
    .elem_i       (elem_i),
    .elem_ready_o (elem_ready_o),
    .NV_o         (NV_o),
    .CI_o         (CI_o),
    .RP_o         (RP_o),
    .rows_o       (rows_o),
    .nnz_o        (nnz_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // CSR from the dense matrix: values in scan order, RP[r+1] = nonzeros in rows 0..r (capped).
  function automatic void model(input int rows, input int cols);
    int cnt = 0;
    exp_nv = '0; exp_ci = '0; exp_rp = '0; exp_nnz = 0; exp_ovf = 1'b0;
    if (rows == 0 || cols == 0 || cols > 16) return;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (mat[r*cols + c] != 32'd0) begin
          if (cnt < 16) begin
            exp_nv[511 - 32*cnt -: 32] = mat[r*cols + c];
            exp_ci[511 - 32*cnt -: 32] = 32'(c);
          end
          cnt++;
        end
      end
      exp_rp[511 - 32*(r+1) -: 32] = 32'((cnt > 16) ? 16 : cnt);
    end
    exp_nnz = (cnt > 16) ? 16 : cnt;
    exp_ovf = (cnt > 16);
`ifdef CSR_ENC_RP_PAD_EN
    for (int k = rows + 1; k < 16; k++) exp_rp[511 - 32*k -: 32] = 32'(exp_nnz);
`endif
  endfunction

  task automatic start_enc(input int r, input int c);
    @(negedge clk_i);
    rows_i = 4'(r); cols_i = 5'(c); start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Starts an encode, streams mat[], then checks latency, handshake and every output.
  task automatic run_case(input string name, input int rows, input int cols,
                          input bit gaps, input bit inject_start);
    int idx = 0, budget = 0, run = 0;
    bit v = 1'b1, ok = 1'b1;
    bit bad_dims = (rows == 0 || cols == 0 || cols > 16);
    start_enc(rows, cols);
    while (!bad_dims && idx < rows*cols && budget < 3000) begin
      if (gaps) begin
        if (run == 0) begin v = !v; run = int'($urandom_range(1, 4)); end
        run--;
      end else v = 1'b1;
      elem_valid_i = v;
      elem_i = v ? mat[idx] : $urandom;
      start_i = inject_start && idx == 2;
      if (start_i) begin rows_i = 4'($urandom); cols_i = 5'($urandom); end
      if (elem_ready_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) ok = 1'b0;
      @(posedge clk_i);
      if (v) idx++;
      budget++;
      @(negedge clk_i);
    end
    elem_valid_i = 1'b0; start_i = 1'b0;
    tests++;
    if (budget >= 3000) begin
      fails++; $display("FAIL %s stream_timeout accepted=%0d required=%0d", name, idx, rows*cols);
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL %s load_handshake ready/busy/done not 1/1/0 during LOAD", name); end
    tests++;
    if ({done_o, busy_o, elem_ready_o} !== 3'b010) begin
      fails++; $display("FAIL %s finish_cycle done,busy,ready=%b required=010", name, {done_o, busy_o, elem_ready_o});
    end
    @(negedge clk_i);
    tests++;
    if ({done_o, busy_o, elem_ready_o} !== 3'b100) begin
      fails++; $display("FAIL %s done_cycle done,busy,ready=%b required=100", name, {done_o, busy_o, elem_ready_o});
    end
    model(rows, cols);
    tests++;
    if (NV_o !== exp_nv) begin fails++; $display("FAIL %s NV act=%h req=%h", name, NV_o, exp_nv); end
    tests++;
    if (CI_o !== exp_ci) begin fails++; $display("FAIL %s CI act=%h req=%h", name, CI_o, exp_ci); end
    tests++;
    if (RP_o !== exp_rp) begin fails++; $display("FAIL %s RP act=%h req=%h", name, RP_o, exp_rp); end
    tests++;
    if (nnz_o !== 5'(exp_nnz) || ovf_o !== exp_ovf || rows_o !== 4'(rows)) begin
      fails++;
      $display("FAIL %s scalars nnz=%0d ovf=%b rows=%0d req nnz=%0d ovf=%b rows=%0d",
               name, nnz_o, ovf_o, rows_o, exp_nnz, exp_ovf, rows);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; rows_i = '0; cols_i = '0; elem_valid_i = 1'b0; elem_i = '0;
    #12;
    tests++;
    if ({NV_o, CI_o, RP_o} !== '0) begin fails++; $display("FAIL reset buses act_nonzero req=0"); end
    tests++;
    if ({rows_o, nnz_o, busy_o, done_o, ovf_o, elem_ready_o} !== '0) begin
      fails++; $display("FAIL reset scalars act=%b req=0", {rows_o, nnz_o, busy_o, done_o, ovf_o, elem_ready_o});
    end
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i);
    tests++;
    if ({busy_o, done_o, elem_ready_o} !== 3'b000) begin
      fails++; $display("FAIL reset_idle busy,done,ready=%b req=000", {busy_o, done_o, elem_ready_o});
    end
  endtask

  task automatic test_basic();
    logic [31:0] m [0:5] = '{32'd5, 32'd0, 32'd7, 32'd0, 32'd0, 32'd9};
    for (int i = 0; i < 6; i++) mat[i] = m[i];
    run_case("basic", 2, 3, 1'b0, 1'b0);
    tests++;
    if (NV_o[511 -: 96] !== {32'd5, 32'd7, 32'd9} || CI_o[511 -: 96] !== {32'd0, 32'd2, 32'd2} ||
        RP_o[511 -: 96] !== {32'd0, 32'd2, 32'd3}) begin
      fails++; $display("FAIL basic_literal NV=%h CI=%h RP=%h req 5,7,9/0,2,2/0,2,3",
                        NV_o[511 -: 96], CI_o[511 -: 96], RP_o[511 -: 96]);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 4; i++) run_case("gaps", 2, 3, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) mat[i] = 32'd1;
    run_case("overflow", 4, 5, 1'b0, 1'b0);
    tests++;
    if (nnz_o !== 5'd16 || ovf_o !== 1'b1 || RP_o[511 -: 160] !== {32'd0, 32'd5, 32'd10, 32'd15, 32'd16}) begin
      fails++; $display("FAIL overflow_literal nnz=%0d ovf=%b RP=%h", nnz_o, ovf_o, RP_o[511 -: 160]);
    end
  endtask

  task automatic test_sparse_rows();
    logic [31:0] m [0:5] = '{32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 6; i++) mat[i] = m[i];
    run_case("sparse_rows", 3, 2, 1'b0, 1'b0);
    tests++;
    if (RP_o[511 -: 128] !== {32'd0, 32'd0, 32'd1, 32'd1} || nnz_o !== 5'd1) begin
      fails++; $display("FAIL sparse_literal RP=%h nnz=%0d req 0,0,1,1 nnz=1", RP_o[511 -: 128], nnz_o);
    end
  endtask

  task automatic test_start_handling();
    for (int i = 0; i < 256; i++) mat[i] = ($urandom_range(0, 1) != 0) ? $urandom : 32'd0;
    run_case("start_mid_load", 2, 3, 1'b0, 1'b1);
    // start from DONE with rows=0: cleared next cycle, done two cycles after start
    @(negedge clk_i); rows_i = 4'd0; cols_i = 5'd3; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b1 || {NV_o, CI_o, RP_o} !== '0 || nnz_o !== 5'd0) begin
      fails++; $display("FAIL start_in_done done=%b busy=%b nnz=%0d req done=0 busy=1 buses/nnz=0", done_o, busy_o, nnz_o);
    end
    @(negedge clk_i);
    tests++;
    if (done_o !== 1'b1 || {NV_o, CI_o, RP_o} !== '0) begin
      fails++; $display("FAIL rows0_done done=%b req=1 with zero buses", done_o);
    end
    start_enc(3, 4);
    for (int i = 0; i < 5; i++) begin
      elem_valid_i = 1'b1; elem_i = 32'd3 + 32'(i);
      @(negedge clk_i);
    end
    elem_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    tests++;
    if ({NV_o, CI_o, RP_o} !== '0 || {rows_o, nnz_o, busy_o, done_o, ovf_o, elem_ready_o} !== '0) begin
      fails++; $display("FAIL rst_mid_load scalars=%b req all 0", {rows_o, nnz_o, busy_o, done_o, ovf_o, elem_ready_o});
    end
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i);
    tests++;
    if ({busy_o, done_o, elem_ready_o} !== 3'b000) begin
      fails++; $display("FAIL rst_idle busy,done,ready=%b req=000", {busy_o, done_o, elem_ready_o});
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int r = int'($urandom_range(0, 15));
      int c = int'($urandom_range(0, 18));
      for (int i = 0; i < 256; i++) mat[i] = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
      run_case("random", r, c, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_sparse_rows();
    test_start_handling();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
